disp_scan_7seg: RTL and testbench
=================================

DISP_SCAN_7SEG -- requirements
Module: disp_scan_7seg

Interface
REQ-001 Parameter N_DIGITS, default 4: digit count, 2..8.
REQ-002 Parameter SCAN_DIV, default 1000: clocks per digit slot, >= 2.
REQ-003 Parameter BLINK_DIV, default 64: full frames per blink half-period, >= 1.
REQ-004 Parameter ACTIVE_LOW, default 0: 1 inverts seg_out, dp_out, an_out.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 digits_in  in  4*N_DIGITS  BCD nibbles; nibble i = digit i; digit 0 least significant.
REQ-008 dp_in  in  N_DIGITS  decimal-point request per digit.
REQ-009 blink_en_in  in  N_DIGITS  per-digit blink enable.
REQ-010 blank_lz_in  in  1  leading-zero blanking enable.
REQ-011 load_in  in  1  one-cycle strobe; capture digits_in and dp_in.
REQ-012 seg_out  out  7  segments {A,B,C,D,E,F,G}, bit 6 = A, 1 = lit before polarity.
REQ-013 dp_out  out  1  decimal point of the selected digit.
REQ-014 an_out  out  N_DIGITS  one-hot digit enable; bit i selects digit i.
REQ-015 frame_out  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to 0.

Function
REQ-016 Prescaler counts 0..SCAN_DIV-1 and wraps; the terminal count is the scan tick.
REQ-017 On each tick, index idx advances by 1, wrapping from N_DIGITS-1 to 0; frame_out pulses in the cycle after the wrap edge.
REQ-018 load_in copies digits_in and dp_in into the pending register on the next edge.
REQ-019 Pending is copied into the active register on the wrap edge only; the displayed value never changes mid-frame.
REQ-020 If load_in coincides with the wrap tick, active takes digits_in and dp_in directly, and pending also updates.
REQ-021 Decode table: 0-9 -> 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011; nibbles 10-15 -> 0000000.
REQ-022 Leading-zero blanking: with blank_lz_in=1, digit i>0 forces seg to 0000000 when digits N_DIGITS-1..i are all zero; digit 0 is never blanked; dp is unaffected.
REQ-023 Blink phase toggles after every BLINK_DIV frame wraps; in phase 1, digits with blink_en_in set drive seg=0000000 and dp=0, with the anode still asserted.
REQ-024 All outputs are registered, one cycle after idx and the prescaler.
REQ-025 Ghost guard: an_out is all-off during the first cycle of each digit slot (prescaler==0); for the remaining SCAN_DIV-1 cycles, the an_out bit for idx is on.
REQ-026 ACTIVE_LOW applies after all blanking and guard logic, as a pure bitwise inversion.

Reset
REQ-027 On rst=1 at an edge: prescaler=0, idx=0, pending=0, active=0, dp registers=0, blink phase=0, blink frame count=0.
REQ-028 During and immediately after reset: seg_out, dp_out and an_out are off (polarity-adjusted) and frame_out=0.
REQ-029 rst asserted mid-frame aborts the scan and discards a pending load; scanning restarts at digit 0 showing 0.

Structure
REQ-030 Package disp_pkg holds typedef seg7_t (7 bits), constant SEG_BLANK, and the decode table from REQ-021.
REQ-031 Sub-module seg7_decode (combinational, nibble -> seg7_t) is instantiated once, on the selected nibble.

Verification (N_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2, ACTIVE_LOW=0 unless stated)
REQ-032 Reset held 3 cycles -> seg_out=0000000, an_out=0000, dp_out=0, frame_out=0 throughout; after release, digit 0 shows 1111110.
REQ-033 load digits_in=16'h1234 mid-frame -> unchanged until the next frame_out; then slots 0..3 show 0110011, 1111001, 1101101, 0110000 with an_out 0001, 0010, 0100, 1000, each off for the first slot cycle.
REQ-034 digits_in=16'h0070, blank_lz_in=1, dp_in=4'b1000 -> digits 3 and 2 seg 0000000 (digit 3 dp_out=1), digit 1 = 1110000, digit 0 = 1111110.
REQ-035 digits_in=16'h00AF -> digits 0 and 1 seg 0000000; with ACTIVE_LOW=1 the same digits drive seg_out=1111111.
REQ-036 blink_en_in=0001 -> digit 0 lit in frames 0-1, blank in frames 2-3, lit in frames 4-5; other digits always lit.
REQ-037 load_in on the wrap-tick cycle with 16'h9999 -> the following frame shows 1111011 on all digits.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and the BCD-to-seven-segment table for the display scanner.
package disp_pkg;

    // Segment vector {A,B,C,D,E,F,G}, bit 6 = A, 1 = lit.
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b000_0000;

    // Index = nibble value; codes 10..15 are not BCD and stay dark.
    localparam seg7_t SEG_TABLE [16] = '{
        7'b111_1110,  // 0
        7'b011_0000,  // 1
        7'b110_1101,  // 2
        7'b111_1001,  // 3
        7'b011_0011,  // 4
        7'b101_1011,  // 5
        7'b101_1111,  // 6
        7'b111_0000,  // 7
        7'b111_1111,  // 8
        7'b111_1011,  // 9
        SEG_BLANK, SEG_BLANK, SEG_BLANK,
        SEG_BLANK, SEG_BLANK, SEG_BLANK
    };

    function automatic seg7_t seg7_lookup(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to segment-pattern decoder.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    assign seg_o = seg7_lookup(nibble_i);

endmodule

// File: rtl/disp_scan_7seg.sv
// Multiplexed seven-segment scanner: prescaled digit scan, frame-aligned
// double-buffered display data, leading-zero blanking, per-digit blink and
// a one-cycle anode guard at the start of every digit slot.
module disp_scan_7seg
    import disp_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 64,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blink_en_in,
    input  logic                  blank_lz_in,
    input  logic                  load_in,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_out
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    localparam seg7_t SEG_POL = {7{ACTIVE_LOW}};

    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_dig_q, pend_dig_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*N_DIGITS-1:0] act_dig_q, act_dig_d;
    logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
    logic                  blk_ph_q, blk_ph_d;

    seg7_t                 seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_q;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nibble_sel;
    seg7_t                 seg_dec;
    logic                  lz_hit;
    logic                  blink_hit;

    assign tick = (presc_q == PRE_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    // Scan position, data buffers and blink timing for the next cycle.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + PRE_W'(1);
        idx_d      = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        pend_dig_d = load_in ? digits_in : pend_dig_q;
        pend_dp_d  = load_in ? dp_in     : pend_dp_q;

        // A load landing on the wrap edge bypasses pending so it is not a frame late.
        act_dig_d  = act_dig_q;
        act_dp_d   = act_dp_q;
        if (wrap) begin
            act_dig_d = load_in ? digits_in : pend_dig_q;
            act_dp_d  = load_in ? dp_in     : pend_dp_q;
        end

        blk_cnt_d  = blk_cnt_q;
        blk_ph_d   = blk_ph_q;
        if (wrap) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                blk_ph_d  = ~blk_ph_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    assign nibble_sel = act_dig_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_dec (
        .nibble_i (nibble_sel),
        .seg_o    (seg_dec)
    );

    // Selected digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        lz_hit = 1'b0;
        if (blank_lz_in && (idx_q != '0)) begin
            lz_hit = 1'b1;
            for (int i = 0; i < N_DIGITS; i++) begin
                if ((IDX_W'(i) >= idx_q) && (act_dig_q[4*i +: 4] != 4'd0)) begin
                    lz_hit = 1'b0;
                end
            end
        end
    end

    assign blink_hit = blk_ph_q && blink_en_in[idx_q];

    // Output values for the slot being scanned, polarity applied last.
    always_comb begin
        seg_d = (lz_hit || blink_hit) ? SEG_BLANK : seg_dec;
        seg_d = seg_d ^ SEG_POL;
        dp_d  = (act_dp_q[idx_q] && !blink_hit) ^ ACTIVE_LOW;
        an_d  = (presc_q == '0) ? '0 : (N_DIGITS'(1) << idx_q);
        an_d  = an_d ^ {N_DIGITS{ACTIVE_LOW}};
    end

    // State and registered outputs; reset aborts the scan and drops any pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            blk_cnt_q  <= '0;
            blk_ph_q   <= 1'b0;
            seg_q      <= SEG_POL;
            dp_q       <= ACTIVE_LOW;
            an_q       <= {N_DIGITS{ACTIVE_LOW}};
            frame_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            blk_cnt_q  <= blk_cnt_d;
            blk_ph_q   <= blk_ph_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            frame_q    <= wrap;
        end
    end

    assign seg_out   = seg_q;
    assign dp_out    = dp_q;
    assign an_out    = an_q;
    assign frame_out = frame_q;

endmodule

// File: tb/tb_disp_scan_7seg.sv
// Directed bench for disp_scan_7seg: N_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2,
// with a second ACTIVE_LOW=1 instance driven from the same inputs.
module tb_disp_scan_7seg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_en_in = '0;
    logic        blank_lz_in = 1'b0;
    logic        load_in = 1'b0;

    logic [6:0]  seg_out, seg_out_al;
    logic        dp_out, dp_out_al;
    logic [3:0]  an_out, an_out_al;
    logic        frame_out, frame_out_al;

    int checks = 0;
    int errors = 0;

    // One captured frame: entry c = slot c/4, cycle c%4 of that slot.
    logic [6:0]  obs_seg    [16];
    logic [6:0]  obs_seg_al [16];
    logic [3:0]  obs_an     [16];
    logic [3:0]  obs_an_al  [16];
    logic        obs_dp     [16];
    logic        obs_dp_al  [16];
    logic        obs_frame  [16];

    always #5 clk = ~clk;

    disp_scan_7seg #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
        .blink_en_in(blink_en_in), .blank_lz_in(blank_lz_in), .load_in(load_in),
        .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_out(frame_out)
    );

    disp_scan_7seg #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
        .blink_en_in(blink_en_in), .blank_lz_in(blank_lz_in), .load_in(load_in),
        .seg_out(seg_out_al), .dp_out(dp_out_al), .an_out(an_out_al), .frame_out(frame_out_al)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_out is seen; bounded so a dead scan cannot hang the run.
    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (frame_out !== 1'b1 && n < 40);
        checks++;
        if (frame_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_frame: frame_out=%b after %0d cycles, expected 1", tag, frame_out, n);
        end
    endtask

    // Record the 16 output cycles following a frame_out sample.
    task automatic capture_frame();
        for (int c = 0; c < 16; c++) begin
            step();
            obs_seg[c]    = seg_out;
            obs_seg_al[c] = seg_out_al;
            obs_an[c]     = an_out;
            obs_an_al[c]  = an_out_al;
            obs_dp[c]     = dp_out;
            obs_dp_al[c]  = dp_out_al;
            obs_frame[c]  = frame_out;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (seg_out !== 7'b0000000 || an_out !== 4'b0000 || dp_out !== 1'b0 || frame_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: seg=%b an=%b dp=%b frame=%b, expected 0000000 0000 0 0",
                         i, seg_out, an_out, dp_out, frame_out);
            end
            checks++;
            if (seg_out_al !== 7'b1111111 || an_out_al !== 4'b1111 || dp_out_al !== 1'b1 || frame_out_al !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_al cyc %0d: seg=%b an=%b dp=%b frame=%b, expected 1111111 1111 1 0",
                         i, seg_out_al, an_out_al, dp_out_al, frame_out_al);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (seg_out !== 7'b1111110 || an_out !== 4'b0000 || frame_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_guard: seg=%b an=%b frame=%b, expected 1111110 0000 0",
                     seg_out, an_out, frame_out);
        end
        step();
        checks++;
        if (seg_out !== 7'b1111110 || an_out !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release_digit0: seg=%b an=%b, expected 1111110 0001", seg_out, an_out);
        end
        checks++;
        if (seg_out_al !== 7'b0000001 || an_out_al !== 4'b1110) begin
            errors++;
            $display("FAIL reset_release_digit0_al: seg=%b an=%b, expected 0000001 1110", seg_out_al, an_out_al);
        end
    endtask

    task automatic test_load_midframe();
        logic [6:0] exp_seg [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        logic [3:0] exp_an;
        wait_frame("load_mid");
        for (int i = 0; i < 5; i++) step();
        digits_in = 16'h1234;
        load_in   = 1'b1;
        step();
        load_in   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (seg_out !== 7'b1111110) begin
                errors++;
                $display("FAIL load_mid_unchanged cyc %0d: seg=%b, expected 1111110", i, seg_out);
            end
        end
        checks++;
        if (frame_out !== 1'b1) begin
            errors++;
            $display("FAIL load_mid_frame_edge: frame_out=%b, expected 1", frame_out);
        end
        capture_frame();
        for (int c = 0; c < 16; c++) begin
            exp_an = (c % 4 == 0) ? 4'b0000 : 4'(1 << (c / 4));
            checks++;
            if (obs_seg[c] !== exp_seg[c / 4] || obs_an[c] !== exp_an || obs_dp[c] !== 1'b0) begin
                errors++;
                $display("FAIL load_mid_scan slot %0d cyc %0d: seg=%b an=%b dp=%b, expected %b %b 0",
                         c / 4, c % 4, obs_seg[c], obs_an[c], obs_dp[c], exp_seg[c / 4], exp_an);
            end
            checks++;
            if (obs_frame[c] !== (c == 15)) begin
                errors++;
                $display("FAIL load_mid_frame_pulse cyc %0d: frame_out=%b, expected %b", c, obs_frame[c], (c == 15));
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_seg [4] = '{7'b1111110, 7'b1110000, 7'b0000000, 7'b0000000};
        logic       exp_dp  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        digits_in   = 16'h0070;
        dp_in       = 4'b1000;
        blank_lz_in = 1'b1;
        load_in     = 1'b1;
        step();
        load_in     = 1'b0;
        wait_frame("lz");
        capture_frame();
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_seg[c] !== exp_seg[c / 4] || obs_dp[c] !== exp_dp[c / 4]) begin
                errors++;
                $display("FAIL lz_blank slot %0d cyc %0d: seg=%b dp=%b, expected %b %b",
                         c / 4, c % 4, obs_seg[c], obs_dp[c], exp_seg[c / 4], exp_dp[c / 4]);
            end
        end
    endtask

    task automatic test_invalid_nibbles();
        logic [6:0] exp_seg [4] = '{7'b0000000, 7'b0000000, 7'b1111110, 7'b1111110};
        logic [3:0] exp_an;
        digits_in   = 16'h00AF;
        dp_in       = 4'b0000;
        blank_lz_in = 1'b0;
        load_in     = 1'b1;
        step();
        load_in     = 1'b0;
        wait_frame("invalid");
        capture_frame();
        for (int c = 0; c < 16; c++) begin
            exp_an = (c % 4 == 0) ? 4'b0000 : 4'(1 << (c / 4));
            checks++;
            if (obs_seg[c] !== exp_seg[c / 4]) begin
                errors++;
                $display("FAIL invalid_seg slot %0d cyc %0d: seg=%b, expected %b",
                         c / 4, c % 4, obs_seg[c], exp_seg[c / 4]);
            end
            checks++;
            if (obs_seg_al[c] !== ~exp_seg[c / 4] || obs_an_al[c] !== ~exp_an || obs_dp_al[c] !== 1'b1) begin
                errors++;
                $display("FAIL invalid_active_low slot %0d cyc %0d: seg=%b an=%b dp=%b, expected %b %b 1",
                         c / 4, c % 4, obs_seg_al[c], obs_an_al[c], obs_dp_al[c], ~exp_seg[c / 4], ~exp_an);
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 3; i++) step();
        digits_in = 16'h8888;
        dp_in     = 4'b1111;
        load_in   = 1'b1;
        step();
        load_in   = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (seg_out !== 7'b0000000 || an_out !== 4'b0000 || dp_out !== 1'b0 || frame_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: seg=%b an=%b dp=%b frame=%b, expected 0000000 0000 0 0",
                     seg_out, an_out, dp_out, frame_out);
        end
        rst = 1'b0;
        wait_frame("midreset");
        capture_frame();
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_seg[c] !== 7'b1111110 || obs_dp[c] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_discard slot %0d cyc %0d: seg=%b dp=%b, expected 1111110 0",
                         c / 4, c % 4, obs_seg[c], obs_dp[c]);
            end
        end
    endtask

    task automatic test_blink();
        logic [6:0] lit_seg [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        logic       exp_dp;
        logic       lit0;
        rst = 1'b1;
        step();
        rst         = 1'b0;
        digits_in   = 16'h1234;
        dp_in       = 4'b0001;
        blink_en_in = 4'b0001;
        load_in     = 1'b1;
        step();
        load_in     = 1'b0;
        wait_frame("blink");
        for (int f = 1; f <= 5; f++) begin
            lit0 = !(f == 2 || f == 3);
            capture_frame();
            for (int c = 0; c < 16; c++) begin
                exp_seg = (c / 4 == 0 && !lit0) ? 7'b0000000 : lit_seg[c / 4];
                exp_dp  = (c / 4 == 0) && lit0;
                exp_an  = (c % 4 == 0) ? 4'b0000 : 4'(1 << (c / 4));
                checks++;
                if (obs_seg[c] !== exp_seg || obs_dp[c] !== exp_dp || obs_an[c] !== exp_an) begin
                    errors++;
                    $display("FAIL blink frame %0d slot %0d cyc %0d: seg=%b dp=%b an=%b, expected %b %b %b",
                             f, c / 4, c % 4, obs_seg[c], obs_dp[c], obs_an[c], exp_seg, exp_dp, exp_an);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        blink_en_in = 4'b0000;
        dp_in       = 4'b0000;
        for (int i = 0; i < 15; i++) step();
        digits_in = 16'h9999;
        load_in   = 1'b1;
        step();
        load_in   = 1'b0;
        digits_in = 16'h1111;
        checks++;
        if (frame_out !== 1'b1) begin
            errors++;
            $display("FAIL wrapload_alignment: frame_out=%b, expected 1", frame_out);
        end
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            for (int c = 0; c < 16; c++) begin
                checks++;
                if (obs_seg[c] !== 7'b1111011) begin
                    errors++;
                    $display("FAIL wrapload frame %0d slot %0d cyc %0d: seg=%b, expected 1111011",
                             f, c / 4, c % 4, obs_seg[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_leading_zero();
        test_invalid_nibbles();
        test_reset_midframe();
        test_blink();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
